// File: rtl/mcpu_ctrl_if.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl_if
// Bundle between the multi-cycle MIPS control FSM and its datapath.
//   Datapath -> control : OPcode, Fun (instruction register fields), zero
//                         (ALU flag), MIO_ready (memory/IO handshake)
//   Control -> datapath : PC/IR/register-file/memory enables, mux selects,
//                         ALU_Control, CPU_MIO bus ownership, debug state
//                         code and the stall watchdog pulse err
// master = control FSM side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mcpu_ctrl_if;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       Jal;
  logic [2:0] ALU_Control;
  logic       CPU_MIO;
  logic [3:0] state;
  logic       err;

  modport master (
    input  OPcode, Fun, zero, MIO_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource, Jal, ALU_Control,
           CPU_MIO, state, err
  );

  modport slave (
    output OPcode, Fun, zero, MIO_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource, Jal, ALU_Control,
           CPU_MIO, state, err
  );
endinterface

// File: rtl/mcpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl_fsm
// Multi-cycle MIPS control FSM. One datapath phase per state; the shared
// memory phases (IF, MEM_RD, MEM_WR) wait on MIO_ready and a stall watchdog
// pulses err once when a single wait reaches TIMEOUT cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (all outputs 0, ALU_Control=add)
//   bus  - mcpu_ctrl_if.master: instruction fields, zero, MIO_ready in;
//          datapath enables/selects, ALU_Control, CPU_MIO, state, err out
// Outputs are decodes of the state register; PCWriteCond (EX_BR) and the
// IF-phase IRWrite/PCWrite additionally depend on zero / MIO_ready.
// ---------------------------------------------------------------------------
module mcpu_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mcpu_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_WB_R    = 4'd3,
    S_EX_I    = 4'd4,
    S_WB_I    = 4'd5,
    S_EX_MEM  = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_LW   = 4'd8,
    S_MEM_WR  = 4'd9,
    S_EX_BR   = 4'd10,
    S_EX_J    = 4'd11,
    S_EX_JR   = 4'd12,
    S_EX_JAL  = 4'd13,
    S_EX_JALR = 4'd14,
    S_WB_LUI  = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [7:0] STALL_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  // R-type function decode: {supported, ALU code}
  function automatic logic [3:0] fun_decode(input logic [5:0] fun);
    logic [3:0] d;
    case (fun)
      6'b100000, 6'b100001: d = {1'b1, ALU_ADD};
      6'b100010, 6'b100011: d = {1'b1, ALU_SUB};
      6'b100100:            d = {1'b1, ALU_AND};
      6'b100101:            d = {1'b1, ALU_OR};
      6'b100110:            d = {1'b1, ALU_XOR};
      6'b100111:            d = {1'b1, ALU_NOR};
      6'b101010:            d = {1'b1, ALU_SLT};
      6'b000010:            d = {1'b1, ALU_SRL};
      default:              d = {1'b0, ALU_ADD};
    endcase
    return d;
  endfunction

  // I-type ALU operation selected by the latched opcode
  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    logic [2:0] a;
    case (op)
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      OP_XORI: a = ALU_XOR;
      OP_SLTI: a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] op_r;
  logic [7:0] stall_cnt_r;
  logic [7:0] stall_cnt_nxt_s;
  logic       stall_s;
  logic       err_s;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic [1:0] mem_to_reg_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] pc_source_s;
  logic       jal_s;
  logic [2:0] alu_ctrl_s;
  logic       cpu_mio_s;

  // State, latched opcode and stall counter registers
  // (the opcode is captured in ID so later phases ignore OPcode changes)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IF;
      op_r        <= 6'd0;
      stall_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      if (state_r == S_ID) begin
        op_r <= bus.OPcode;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Stall watchdog: counts consecutive unready memory cycles, saturating
  always_comb begin
    stall_s         = 1'b0;
    stall_cnt_nxt_s = 8'd0;
    err_s           = 1'b0;
    if ((state_r == S_IF) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR)) begin
      stall_s = ~bus.MIO_ready;
    end else begin
      stall_s = 1'b0;
    end
    if (!stall_s) begin
      stall_cnt_nxt_s = 8'd0;
    end else if (stall_cnt_r == STALL_MAX) begin
      stall_cnt_nxt_s = stall_cnt_r;
    end else begin
      stall_cnt_nxt_s = stall_cnt_r + 8'd1;
    end
    // fires in the cycle the count reaches TIMEOUT; saturation keeps it single
    if (rst) begin
      err_s = 1'b0;
    end else begin
      err_s = stall_s && (stall_cnt_r == STALL_LAST);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt_s     = state_r;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    mem_to_reg_s    = 2'b00;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    pc_source_s     = 2'b00;
    jal_s           = 1'b0;
    alu_ctrl_s      = ALU_ADD;
    cpu_mio_s       = 1'b0;
    if (rst) begin
      // outputs held at their idle values while reset is asserted
      state_nxt_s = S_IF;
    end else begin
      case (state_r)
        S_IF: begin
          mem_read_s  = 1'b1;
          alu_src_b_s = 2'b01;
          cpu_mio_s   = 1'b1;
          ir_write_s  = bus.MIO_ready;
          pc_write_s  = bus.MIO_ready;
          if (bus.MIO_ready) begin
            state_nxt_s = S_ID;
          end else begin
            state_nxt_s = S_IF;
          end
        end
        S_ID: begin
          // branch target computed here and parked in ALUOut
          alu_src_b_s = 2'b11;
          case (bus.OPcode)
            OP_RTYPE: begin
              if (bus.Fun == FN_JR) begin
                state_nxt_s = S_EX_JR;
              end else if (bus.Fun == FN_JALR) begin
                state_nxt_s = S_EX_JALR;
              end else if (fun_decode(bus.Fun) >= 4'd8) begin
                state_nxt_s = S_EX_R;
              end else begin
                state_nxt_s = S_IF;
              end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_nxt_s = S_EX_I;
            OP_LW, OP_SW:   state_nxt_s = S_EX_MEM;
            OP_BEQ, OP_BNE: state_nxt_s = S_EX_BR;
            OP_J:           state_nxt_s = S_EX_J;
            OP_JAL:         state_nxt_s = S_EX_JAL;
            OP_LUI:         state_nxt_s = S_WB_LUI;
            default:        state_nxt_s = S_IF;
          endcase
        end
        S_EX_R: begin
          alu_src_a_s = 1'b1;
          alu_ctrl_s  = fun_decode(bus.Fun)[2:0];
          state_nxt_s = S_WB_R;
        end
        S_WB_R: begin
          reg_dst_s   = 1'b1;
          reg_write_s = 1'b1;
          state_nxt_s = S_IF;
        end
        S_EX_I: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = 2'b10;
          alu_ctrl_s  = imm_alu(op_r);
          state_nxt_s = S_WB_I;
        end
        S_WB_I: begin
          reg_write_s = 1'b1;
          state_nxt_s = S_IF;
        end
        S_EX_MEM: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = 2'b10;
          if (op_r == OP_SW) begin
            state_nxt_s = S_MEM_WR;
          end else begin
            state_nxt_s = S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          iord_s     = 1'b1;
          mem_read_s = 1'b1;
          cpu_mio_s  = 1'b1;
          if (bus.MIO_ready) begin
            state_nxt_s = S_WB_LW;
          end else begin
            state_nxt_s = S_MEM_RD;
          end
        end
        S_WB_LW: begin
          mem_to_reg_s = 2'b01;
          reg_write_s  = 1'b1;
          state_nxt_s  = S_IF;
        end
        S_MEM_WR: begin
          iord_s      = 1'b1;
          mem_write_s = 1'b1;
          cpu_mio_s   = 1'b1;
          if (bus.MIO_ready) begin
            state_nxt_s = S_IF;
          end else begin
            state_nxt_s = S_MEM_WR;
          end
        end
        S_EX_BR: begin
          alu_src_a_s = 1'b1;
          alu_ctrl_s  = ALU_SUB;
          pc_source_s = 2'b01;
          if (op_r == OP_BEQ) begin
            pc_write_cond_s = bus.zero;
          end else begin
            pc_write_cond_s = ~bus.zero;
          end
          state_nxt_s = S_IF;
        end
        S_EX_J: begin
          pc_source_s = 2'b10;
          pc_write_s  = 1'b1;
          state_nxt_s = S_IF;
        end
        S_EX_JR: begin
          pc_source_s = 2'b11;
          pc_write_s  = 1'b1;
          state_nxt_s = S_IF;
        end
        S_EX_JAL, S_EX_JALR: begin
          mem_to_reg_s = 2'b11;
          jal_s        = 1'b1;
          reg_write_s  = 1'b1;
          pc_write_s   = 1'b1;
          if (state_r == S_EX_JAL) begin
            pc_source_s = 2'b10;
          end else begin
            pc_source_s = 2'b11;
          end
          state_nxt_s = S_IF;
        end
        S_WB_LUI: begin
          mem_to_reg_s = 2'b10;
          reg_write_s  = 1'b1;
          state_nxt_s  = S_IF;
        end
        default: state_nxt_s = S_IF;
      endcase
    end
  end

  assign bus.PCWrite     = pc_write_s;
  assign bus.PCWriteCond = pc_write_cond_s;
  assign bus.IorD        = iord_s;
  assign bus.MemRead     = mem_read_s;
  assign bus.MemWrite    = mem_write_s;
  assign bus.IRWrite     = ir_write_s;
  assign bus.RegDst      = reg_dst_s;
  assign bus.RegWrite    = reg_write_s;
  assign bus.MemtoReg    = mem_to_reg_s;
  assign bus.ALUSrcA     = alu_src_a_s;
  assign bus.ALUSrcB     = alu_src_b_s;
  assign bus.PCSource    = pc_source_s;
  assign bus.Jal         = jal_s;
  assign bus.ALU_Control = alu_ctrl_s;
  assign bus.CPU_MIO     = cpu_mio_s;
  assign bus.state       = state_r;
  assign bus.err         = err_s;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mcpu_ctrl_fsm
// Random instruction stream with random memory stalls. For every cycle the
// driver pushes the expected control word (derived from the instruction class
// and the phase sequence of that class) into a queue; a negedge monitor pops
// and compares against the DUT. A directed reset-during-store check follows.
// ---------------------------------------------------------------------------
module tb_mcpu_ctrl_fsm;
  localparam int TO = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [5:0] OPS [16] = '{OP_R, OP_R, OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, 6'b111111};
  localparam logic [5:0] FUNS [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000010,
      6'b001000, 6'b001001, 6'b000000, 6'b111111};

  typedef enum {C_NOP, C_R, C_JR, C_JALR, C_I, C_LW, C_SW, C_BEQ, C_BNE,
                C_J, C_JAL, C_LUI} cls_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, rdst, rw;
    logic [1:0] m2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic       jal;
    logic [2:0] alu;
    logic       mio;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mcpu_ctrl_if bus();

  mcpu_ctrl_fsm #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  // ALU code the spec assigns to each R-type function; bit 3 = supported
  function automatic logic [3:0] fun_alu(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: return 4'b1010;
      6'b100010, 6'b100011: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b100110: return 4'b1011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b1111;
      6'b000010: return 4'b1101;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [2:0] op_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: return 3'b000;
      OP_ORI:  return 3'b001;
      OP_XORI: return 3'b011;
      OP_SLTI: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] f);
    logic [3:0] fa;
    fa = fun_alu(f);
    case (op)
      OP_R: begin
        if (f == 6'b001000) return C_JR;
        else if (f == 6'b001001) return C_JALR;
        else if (fa[3]) return C_R;
        else return C_NOP;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: return C_I;
      OP_LW:  return C_LW;
      OP_SW:  return C_SW;
      OP_BEQ: return C_BEQ;
      OP_BNE: return C_BNE;
      OP_J:   return C_J;
      OP_JAL: return C_JAL;
      OP_LUI: return C_LUI;
      default: return C_NOP;
    endcase
  endfunction

  // idle control word: everything 0, ALU add
  function automatic exp_t blank(input logic [3:0] st);
    exp_t b;
    b = '0;
    b.st = st;
    b.alu = 3'b010;
    return b;
  endfunction

  // memory-phase word (IF=0, MEM_RD=7, MEM_WR=9), ready or stalled
  function automatic exp_t mem_rec(input logic [3:0] st, input logic rdy);
    exp_t e;
    e = blank(st);
    e.mio = 1'b1;
    if (st == 4'd0) begin
      e.mrd = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy;
    end else if (st == 4'd7) begin
      e.iord = 1'b1; e.mrd = 1'b1;
    end else begin
      e.iord = 1'b1; e.mwr = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t cur_out();
    exp_t a;
    a.st = bus.state; a.pcw = bus.PCWrite; a.pcwc = bus.PCWriteCond;
    a.iord = bus.IorD; a.mrd = bus.MemRead; a.mwr = bus.MemWrite;
    a.irw = bus.IRWrite; a.rdst = bus.RegDst; a.rw = bus.RegWrite;
    a.m2r = bus.MemtoReg; a.asa = bus.ALUSrcA; a.asb = bus.ALUSrcB;
    a.pcs = bus.PCSource; a.jal = bus.Jal; a.alu = bus.ALU_Control;
    a.mio = bus.CPU_MIO; a.err = bus.err;
    return a;
  endfunction

  task automatic chk_vec(input string nm, input exp_t req);
    exp_t a;
    a = cur_out();
    n_chk++;
    if (a !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (state got %0d required %0d)",
               nm, a, req, a.st, req.st);
    end
  endtask

  // monitor: one expected control word per cycle while the stream runs
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL underflow: got empty queue required one entry");
      end else begin
        chk_vec("cycle", exp_q.pop_front());
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // one clock of stimulus; entered and left at posedge+1
  task automatic cyc(input exp_t e, input logic mio, input logic z,
                     input logic [5:0] op, input logic [5:0] f);
    bus.MIO_ready = mio;
    bus.zero = z;
    bus.OPcode = op;
    bus.Fun = f;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input logic [3:0] st, input int n,
                           input logic [5:0] op, input logic [5:0] f);
    exp_t e;
    for (int j = 1; j <= n; j++) begin
      e = mem_rec(st, 1'b0);
      e.err = (j == TO);
      cyc(e, 1'b0, rb(), op, f);
    end
    cyc(mem_rec(st, 1'b1), 1'b1, rb(), op, f);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input int if_st, input int mem_st, input logic zb);
    cls_t c;
    exp_t e;
    logic [5:0] opx;
    c = classify(op, f);
    opx = 6'($urandom);
    mem_phase(4'd0, if_st, op, f);
    e = blank(4'd1); e.asb = 2'b11;
    cyc(e, rb(), rb(), op, f);
    case (c)
      C_R: begin
        e = blank(4'd2); e.asa = 1'b1; e.alu = fun_alu(f)[2:0];
        cyc(e, rb(), rb(), opx, f);
        e = blank(4'd3); e.rdst = 1'b1; e.rw = 1'b1;
        cyc(e, rb(), rb(), opx, 6'($urandom));
      end
      C_I: begin
        e = blank(4'd4); e.asa = 1'b1; e.asb = 2'b10; e.alu = op_alu(op);
        cyc(e, rb(), rb(), opx, f);
        e = blank(4'd5); e.rw = 1'b1;
        cyc(e, rb(), rb(), opx, f);
      end
      C_LW, C_SW: begin
        e = blank(4'd6); e.asa = 1'b1; e.asb = 2'b10;
        cyc(e, rb(), rb(), opx, f);
        mem_phase((c == C_LW) ? 4'd7 : 4'd9, mem_st, opx, f);
        if (c == C_LW) begin
          e = blank(4'd8); e.m2r = 2'b01; e.rw = 1'b1;
          cyc(e, rb(), rb(), opx, f);
        end
      end
      C_BEQ, C_BNE: begin
        e = blank(4'd10); e.asa = 1'b1; e.alu = 3'b110; e.pcs = 2'b01;
        e.pcwc = (c == C_BEQ) ? zb : ~zb;
        cyc(e, rb(), zb, opx, f);
      end
      C_J:   begin e = blank(4'd11); e.pcs = 2'b10; e.pcw = 1'b1; cyc(e, rb(), rb(), opx, f); end
      C_JR:  begin e = blank(4'd12); e.pcs = 2'b11; e.pcw = 1'b1; cyc(e, rb(), rb(), opx, f); end
      C_JAL, C_JALR: begin
        e = blank((c == C_JAL) ? 4'd13 : 4'd14);
        e.m2r = 2'b11; e.jal = 1'b1; e.rw = 1'b1; e.pcw = 1'b1;
        e.pcs = (c == C_JAL) ? 2'b10 : 2'b11;
        cyc(e, rb(), rb(), opx, f);
      end
      C_LUI: begin e = blank(4'd15); e.m2r = 2'b10; e.rw = 1'b1; cyc(e, rb(), rb(), opx, f); end
      default: ;
    endcase
  endtask

  function automatic int rstall();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 7));
    else return 0;
  endfunction

  initial begin
    exp_t e;
    bus.OPcode = 6'd0; bus.Fun = 6'd0; bus.zero = 1'b0; bus.MIO_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_vec("reset", blank(4'd0));
    rst = 1'b0;
    chk_en = 1'b1;

    // directed cases
    run_instr(OP_R, 6'b100000, 0, 0, 1'b0);     // add: 0,1,2,3
    run_instr(OP_LW, 6'd0, 0, 3, 1'b0);         // lw, 3 MEM_RD stalls
    run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
    run_instr(OP_BNE, 6'd0, 0, 0, 1'b1);
    run_instr(OP_BNE, 6'd0, 0, 0, 1'b0);
    run_instr(OP_JAL, 6'd0, 0, 0, 1'b0);
    run_instr(6'b111111, 6'd0, 0, 0, 1'b0);
    run_instr(OP_SW, 6'd0, 6, 5, 1'b0);         // err in IF and in MEM_WR
    run_instr(OP_R, 6'b001001, TO, 0, 1'b0);    // jalr, err on last IF stall

    // random stream
    for (int i = 0; i < 250; i++) begin
      run_instr(OPS[$urandom_range(0, 15)], FUNS[$urandom_range(0, 13)],
                rstall(), rstall(), rb());
    end

    // reset while a store is waiting on the bus
    cyc(mem_rec(4'd0, 1'b1), 1'b1, 1'b0, OP_SW, 6'd0);
    e = blank(4'd1); e.asb = 2'b11;
    cyc(e, 1'b0, 1'b0, OP_SW, 6'd0);
    e = blank(4'd6); e.asa = 1'b1; e.asb = 2'b10;
    cyc(e, 1'b0, 1'b0, 6'd0, 6'd0);
    cyc(mem_rec(4'd9, 1'b0), 1'b0, 1'b0, 6'd0, 6'd0);
    chk_en = 1'b0;
    chk_vec("mem_wr_wait", mem_rec(4'd9, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk_vec("rst_async", blank(4'd0));
    @(posedge clk);
    #1;
    chk_vec("rst_held", blank(4'd0));
    rst = 1'b0;
    chk_en = 1'b1;
    run_instr(OP_R, 6'b100010, 0, 0, 1'b0);     // sub after reset
    run_instr(OP_SW, 6'd0, 0, 0, 1'b0);
    chk_en = 1'b0;

    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
